// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable 50 % duty clock dividers with rising-edge strobes.
// Ratio/enable updates are shadowed and applied only at period boundaries so outputs never glitch.
module clk_div_bank #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_W        = 25,
    parameter int unsigned DEFAULT_HALF = 24999,
    parameter int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_half,
    input  logic                cfg_en,
    output logic [CHANNELS-1:0] out_clk,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][CNT_W-1:0] half_q, half_d;
    logic [CHANNELS-1:0][CNT_W-1:0] sh_half_q, sh_half_d;
    logic [CHANNELS-1:0]            en_q, en_d;
    logic [CHANNELS-1:0]            out_q, out_d;
    logic [CHANNELS-1:0]            tick_q, tick_d;
    logic [CHANNELS-1:0]            pend_q, pend_d;
    logic [CHANNELS-1:0]            sh_en_q, sh_en_d;
    logic                           accept;

    // Out-of-range channel selects stay ready so such requests drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_q[i];
            end
        end
    end

    assign accept = cfg_valid & cfg_ready;

    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        sh_half_d = sh_half_q;
        en_d      = en_q;
        out_d     = out_q;
        tick_d    = '0;
        pend_d    = pend_q;
        sh_en_d   = sh_en_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (en_q[i]) begin
                if (cnt_q[i] == half_q[i]) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = ~out_q[i];
                    tick_d[i] = ~out_q[i];
                    // Falling toggle ends a full period: the only safe point to swap ratio.
                    if (out_q[i] && pend_q[i]) begin
                        half_d[i] = sh_half_q[i];
                        en_d[i]   = sh_en_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    half_d[i] = sh_half_q[i];
                    en_d[i]   = sh_en_q[i];
                    pend_d[i] = 1'b0;
                end
            end
            // Cannot collide with an apply: accept requires the channel not pending.
            if (accept && (cfg_ch == CH_W'(i))) begin
                pend_d[i]    = 1'b1;
                sh_half_d[i] = cfg_half;
                sh_en_d[i]   = cfg_en;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            sh_half_q <= '0;
            en_q      <= '1;
            out_q     <= '0;
            tick_q    <= '0;
            pend_q    <= '0;
            sh_en_q   <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                half_q[i] <= CNT_W'(DEFAULT_HALF);
            end
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            sh_half_q <= sh_half_d;
            en_q      <= en_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
            pend_q    <= pend_d;
            sh_en_q   <= sh_en_d;
        end
    end

    assign out_clk = out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: reset-release vector table, directed config sequences and random
// traffic, all checked against a period-phase reference model.
module tb_clk_div_bank;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_half;
    logic       cfg_en;
    logic [3:0] out_clk;
    logic [3:0] tick;

    clk_div_bank #(
        .CHANNELS    (NCH),
        .CNT_W       (8),
        .DEFAULT_HALF(3),
        .CH_W        (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .cfg_en   (cfg_en),
        .out_clk  (out_clk),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit last_acc;

    // Model: each channel is a position within its current period (age since period start).
    int unsigned m_half[NCH];
    int unsigned m_age[NCH];
    bit          m_en[NCH];
    bit          m_pend[NCH];
    int unsigned m_sh_half[NCH];
    bit          m_sh_en[NCH];

    typedef struct {
        int         edge_n;
        logic [3:0] out;
        logic [3:0] tk;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_half[i] = 3; m_age[i] = 0; m_en[i] = 1'b1; m_pend[i] = 1'b0;
            m_sh_half[i] = 0; m_sh_en[i] = 1'b0;
        end
    endfunction

    function automatic bit model_ready(input int ch);
        return (ch >= NCH) || !m_pend[ch];
    endfunction

    function automatic void model_edge(input bit acc, input int ch, input int h, input bit e);
        for (int i = 0; i < NCH; i++) begin
            if (m_en[i]) m_age[i] = (m_age[i] + 1) % (2 * (m_half[i] + 1));
            else m_age[i] = 0;
            if (m_pend[i] && m_age[i] == 0) begin
                m_half[i] = m_sh_half[i]; m_en[i] = m_sh_en[i]; m_pend[i] = 1'b0;
            end
        end
        if (acc && ch < NCH) begin
            m_pend[ch] = 1'b1; m_sh_half[ch] = h; m_sh_en[ch] = e;
        end
    endfunction

    task automatic check_outputs();
        logic [3:0] eo, et;
        for (int i = 0; i < NCH; i++) begin
            eo[i] = m_en[i] && (m_age[i] >= m_half[i] + 1);
            et[i] = m_en[i] && (m_age[i] == m_half[i] + 1);
        end
        check("out_clk", 32'(out_clk), 32'(eo));
        check("tick", 32'(tick), 32'(et));
    endtask

    // Called at posedge+1: drive, check ready mid-cycle, clock, check outputs at posedge+1.
    task automatic cycle(input bit v, input int ch, input int h, input bit e);
        bit exp_rdy;
        cfg_valid = v; cfg_ch = 3'(ch); cfg_half = 8'(h); cfg_en = e;
        #3;
        exp_rdy = model_ready(ch);
        check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
        last_acc = v && exp_rdy;
        @(posedge clk);
        model_edge(last_acc, ch, h, e);
        edge_cnt++;
        #1;
        check_outputs();
    endtask

    task automatic run_table();
        for (int k = 0; k < 12; k++) begin
            while (edge_cnt < tbl[k].edge_n) cycle(1'b0, 1, 0, 1'b0);
            check("table_out", 32'(out_clk), 32'(tbl[k].out));
            check("table_tick", 32'(tick), 32'(tbl[k].tk));
        end
    endtask

    initial begin
        tbl[0]  = '{1, 4'h0, 4'h0};  tbl[1]  = '{3, 4'h0, 4'h0};
        tbl[2]  = '{4, 4'hF, 4'hF};  tbl[3]  = '{5, 4'hF, 4'h0};
        tbl[4]  = '{7, 4'hF, 4'h0};  tbl[5]  = '{8, 4'h0, 4'h0};
        tbl[6]  = '{11, 4'h0, 4'h0}; tbl[7]  = '{12, 4'hF, 4'hF};
        tbl[8]  = '{13, 4'hF, 4'h0}; tbl[9]  = '{15, 4'hF, 4'h0};
        tbl[10] = '{16, 4'h0, 4'h0}; tbl[11] = '{20, 4'hF, 4'hF};

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_en = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_out", 32'(out_clk), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0; edge_cnt = 0;

        // Reset release at default half = 3.
        run_table();

        // ch1 -> half 1 while in high phase; ready for ch1 stays low until apply.
        cycle(1'b1, 1, 1, 1'b1);
        repeat (16) cycle(1'b0, 1, 0, 1'b0);

        // ch2 disabled at next falling toggle, then re-enabled at half 0.
        cycle(1'b1, 2, 3, 1'b0);
        repeat (20) cycle(1'b0, 2, 0, 1'b0);
        check("ch2_off", 32'(out_clk[2]), 32'h0);
        cycle(1'b1, 2, 0, 1'b1);
        repeat (10) cycle(1'b0, 2, 0, 1'b0);

        // Back-to-back ch0: second write stalls; ch3 write during stall goes through.
        cycle(1'b1, 0, 2, 1'b1);
        check("ch0_first_acc", 32'(last_acc), 32'h1);
        cycle(1'b1, 0, 5, 1'b1);
        check("ch0_stall", 32'(last_acc), 32'h0);
        cycle(1'b1, 3, 1, 1'b1);
        check("ch3_acc", 32'(last_acc), 32'h1);
        begin
            int tries = 0;
            do begin
                cycle(1'b1, 0, 5, 1'b1);
                tries++;
            end while (!last_acc && tries < 40);
            check("ch0_second_acc", 32'(last_acc), 32'h1);
        end
        repeat (30) cycle(1'b0, 0, 0, 1'b0);

        // Out-of-range channel is accepted and discarded.
        cycle(1'b1, 5, 0, 1'b0);
        check("ch5_acc", 32'(last_acc), 32'h1);
        repeat (12) cycle(1'b0, 5, 0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 5)), $urandom_range(0, 4) != 0);
        end
        repeat (30) cycle(1'b0, 0, 0, 1'b0);

        // Reset mid-period with ch1 pending.
        begin
            int tries = 0;
            while (!m_pend[1] && tries < 40) begin
                cycle(1'b1, 1, 2, 1'b1);
                tries++;
            end
            check("ch1_pending_before_rst", 32'(m_pend[1]), 32'h1);
        end
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 3'd1;
        #1;
        check("async_rst_out", 32'(out_clk), 32'h0);
        check("async_rst_tick", 32'(tick), 32'h0);
        check("async_rst_ready", 32'(cfg_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; edge_cnt = 0;
        model_reset();
        run_table();
        repeat (20) cycle(1'b0, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
